// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared data-command codes, arbiter state and source encodings
package core_mem_pkg;

    localparam logic [2:0] D_CMD_NONE  = 3'd0;
    localparam logic [2:0] D_CMD_READ  = 3'd1;
    localparam logic [2:0] D_CMD_WRITE = 3'd2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_RD_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_e;

    // Every code other than READ/WRITE is treated as NONE.
    function automatic logic is_data_cmd(input logic [2:0] cmd);
        return (cmd == D_CMD_READ) || (cmd == D_CMD_WRITE);
    endfunction

endpackage

// File: rtl/core_mem_arb_pick.sv
// rtl/core_mem_arb_pick.sv - grant decision between fetch and data ports; ARB_FAIRNESS_EN adds a data-streak limit
module core_mem_arb_pick
    import core_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle,
    input  logic       inst_start,
    input  logic [2:0] d_cmd,
    output logic       inst_ready,
    output logic       d_cmd_ready
);

    logic data_req;
    assign data_req = is_data_cmd(d_cmd);

`ifdef ARB_FAIRNESS_EN
    localparam int CW = $clog2(MAX_DATA_STREAK) + 1;
    localparam logic [CW-1:0] STREAK_MAX = CW'(MAX_DATA_STREAK);

    logic [CW-1:0] streak;
    logic          inst_turn;

    assign inst_turn = (streak == STREAK_MAX) && inst_start;

    always_comb begin
        inst_ready  = 1'b0;
        d_cmd_ready = 1'b0;
        if (idle) begin
            if (data_req && !inst_turn) begin
                d_cmd_ready = 1'b1;
            end else if (inst_start) begin
                inst_ready = 1'b1;
            end
        end
    end

    // Streak only counts data wins taken while a fetch was actually waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (idle) begin
            if (!inst_start || inst_ready) begin
                streak <= '0;
            end else if (d_cmd_ready && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
        end
    end
`else
    logic unused_pick;

    always_comb begin
        inst_ready  = idle && inst_start && !data_req;
        d_cmd_ready = idle && data_req;
    end

    assign unused_pick = &{1'b0, clk, reset, (MAX_DATA_STREAK > 0)};
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - serialises fetch and data ports onto one req/gnt/rvalid memory; optional ARB_FAIRNESS_EN
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_start,
    output logic                  inst_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic [2:0]            d_cmd,
    output logic                  d_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_wmask,
    input  logic                  mem_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    arb_state_e            state;
    arb_state_e            state_next;
    arb_src_e              src_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wmask_q;

    logic idle;
    logic pick_inst;
    logic pick_data;
    logic accept;
    logic resp_fire;

    assign idle = (state == ARB_IDLE);

    core_mem_arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .clk        (clk),
        .reset      (reset),
        .idle       (idle),
        .inst_start (inst_start),
        .d_cmd      (d_cmd),
        .inst_ready (pick_inst),
        .d_cmd_ready(pick_data)
    );

    // State is already IDLE during reset, so the ready outputs need explicit masking.
    assign inst_ready  = pick_inst && !reset;
    assign d_cmd_ready = pick_data && !reset;
    assign accept      = pick_inst || pick_data;

    always_comb begin
        state_next = state;
        resp_fire  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_next = ARB_IDLE;
                    end else if (mem_rvalid) begin
                        resp_fire  = 1'b1;
                        state_next = ARB_IDLE;
                    end else begin
                        state_next = ARB_RD_WAIT;
                    end
                end
            end
            ARB_RD_WAIT: begin
                if (mem_rvalid) begin
                    resp_fire  = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= SRC_INST;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            src_q   <= pick_data ? SRC_DATA : SRC_INST;
            we_q    <= pick_data && (d_cmd == D_CMD_WRITE);
            addr_q  <= pick_data ? d_addr : i_addr;
            wdata_q <= pick_data ? wdata : '0;
            wmask_q <= pick_data ? wmask : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_valid  <= 1'b0;
            rdata_valid <= 1'b0;
            inst        <= '0;
            rdata       <= '0;
        end else begin
            inst_valid  <= resp_fire && (src_q == SRC_INST);
            rdata_valid <= resp_fire && (src_q == SRC_DATA);
            if (resp_fire && (src_q == SRC_INST)) begin
                inst <= mem_rdata;
            end
            if (resp_fire && (src_q == SRC_DATA)) begin
                rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state == ARB_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Sits directly below the core pipeline top and consumes both of its memory request ports: the fetch-side instruction port and the memory-stage data port.
- Serialises them onto one single-ported backing-memory interface with a req/gnt/rvalid handshake.
- Returns instruction words and load data as one-cycle valid pulses.
- Data requests win by default so the memory stage is never starved behind fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data and mask width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed over a pending fetch (used only with ARB_FAIRNESS_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- inst_start  in  1  fetch request.
- inst_ready  out  1  fetch request accepted this cycle when inst_start is also high.
- i_addr  in  ADDR_WIDTH  fetch address.
- inst  out  DATA_WIDTH  fetched word.
- inst_valid  out  1  one-cycle pulse; inst is valid.
- d_cmd  in  3  data command (NONE/READ/WRITE).
- d_cmd_ready  out  1  data command accepted this cycle.
- d_addr  in  ADDR_WIDTH  data address.
- wdata  in  DATA_WIDTH  store data.
- wmask  in  DATA_WIDTH  store bit mask.
- rdata  out  DATA_WIDTH  load data.
- rdata_valid  out  1  one-cycle pulse; rdata is valid.
- mem_req  out  1  backend request.
- mem_we  out  1  backend write enable.
- mem_addr  out  ADDR_WIDTH  backend address.
- mem_wdata  out  DATA_WIDTH  backend write data.
- mem_wmask  out  DATA_WIDTH  backend write mask.
- mem_gnt  in  1  backend accepted the request this cycle.
- mem_rdata  in  DATA_WIDTH  backend read data.
- mem_rvalid  in  1  backend read data valid.

Behaviour:
- Reset:
  - clk is the only clock; reset is asynchronous and active-high.
  - While reset is high: state=IDLE, all registered outputs 0, inst_ready=d_cmd_ready=0.
- States:
  - IDLE: no transaction outstanding.
  - REQ: mem_req held until mem_gnt.
  - RD_WAIT: waiting for mem_rvalid.
- Command decoding and acceptance:
  - d_cmd values other than READ (1) and WRITE (2) are NONE.
  - d_cmd_ready = IDLE && d_cmd is READ/WRITE.
  - inst_ready = IDLE && inst_start && !(d_cmd is READ/WRITE). Ready outputs are combinational.
  - On acceptance: latch source (INST/DATA), we, addr, wdata, wmask; go to REQ.
  - Nothing is accepted outside IDLE.
- REQ:
  - mem_req=1; mem_we/addr/wdata/wmask come from the latched registers and are stable until mem_gnt.
  - On mem_gnt with a write: go to IDLE. Stores produce no response pulse.
  - On mem_gnt with a read: go to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid: registered pulse for exactly 1 cycle on inst_valid or rdata_valid (per the latched source), with inst or rdata = mem_rdata; go to IDLE.
  - mem_rvalid in the same cycle as mem_gnt is legal: the pulse is issued next cycle and RD_WAIT is skipped.
- Output holding: inst and rdata hold their last value between pulses; inst_valid and rdata_valid are otherwise 0.
- Minimum latency for a read, accept to valid, is 2 cycles (gnt and rvalid both immediate).
- Back-to-back: the cycle a transaction completes, state is IDLE the next cycle; a new accept is possible then, so the minimum issue interval is 2 cycles.
- Spurious input: mem_rvalid outside RD_WAIT/REQ is ignored.
- Reset mid-transaction: the outstanding request is dropped with no response pulse; a late mem_rvalid after reset is ignored.
- Address: passed unmodified, no alignment check.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- With the macro:
  - A saturating counter (width clog2(MAX_DATA_STREAK)+1) counts data grants taken in IDLE while inst_start was also high.
  - When the counter equals MAX_DATA_STREAK and both ports request, the instruction port wins: inst_ready=1, d_cmd_ready=0. The counter then clears.
  - The counter also clears on any cycle inst_start is low in IDLE.
- Without the macro: strict data priority, no counter logic synthesised.

Decomposition:
- Shared package core_mem_pkg:
  - D_CMD_NONE=3'd0, D_CMD_READ=3'd1, D_CMD_WRITE=3'd2.
  - Arbiter state encoding.
  - Source enum SRC_INST/SRC_DATA.
- The same package is used by the memory stage for d_cmd.
- One sub-module, core_mem_arb_pick: the combinational grant decision plus the fairness counter (under the macro), so the priority policy can be verified in isolation.

Test Plan:
- Fetch only: i_addr=0x100, gnt immediate, rvalid 1 cycle later with 0x00000013 -> inst=0x00000013, inst_valid high exactly 1 cycle, 3 cycles after accept.
- Store: d_cmd=WRITE, d_addr=0x200, wdata=0xDEADBEEF, wmask=0x0000FFFF, gnt delayed 3 cycles -> mem_req/mem_we/addr/wdata/wmask stable for 4 cycles, no valid pulse, IDLE after gnt.
- Collision: inst_start and d_cmd=READ in the same IDLE cycle -> d_cmd_ready=1, inst_ready=0; fetch is accepted after the load's rdata_valid.
- Same-cycle gnt+rvalid on a load (mem_rdata=0x12345678) -> rdata_valid 1 cycle later with 0x12345678, RD_WAIT never entered.
- Reset asserted in RD_WAIT, then mem_rvalid after release -> no inst_valid/rdata_valid pulse, state IDLE, mem_req=0.
- ARB_FAIRNESS_EN, MAX_DATA_STREAK=4: inst_start held high with 5 consecutive data reads -> first 4 granted to data, 5th arbitration grants fetch.
